// File: rtl/decode_execute_mem_slice.sv
// RV32I datapath slice: ID decode and register file, EX forwarding/ALU/branch, and the EX/MEM register.
// The registered aluResultM doubles as the EX/MEM forwarding source for the execute muxes.
module decode_execute_mem_slice #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instrD,
    input  logic                      regWriteW,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic [DATA_WIDTH-1:0]     resultW,
    input  logic [REG_ADDR_WIDTH-1:0] testRegAddr,
    output logic [DATA_WIDTH-1:0]     testRegData,
    output logic [2:0]                addressingModeD,
    output logic [1:0]                resultSrcD,
    output logic [3:0]                aluControlD,
    output logic                      regWriteD,
    output logic                      memWriteD,
    output logic                      memReadD,
    output logic                      branchD,
    output logic                      jumpD,
    output logic                      jalrD,
    output logic                      aluSrcD,
    output logic [DATA_WIDTH-1:0]     rd1D,
    output logic [DATA_WIDTH-1:0]     rd2D,
    output logic [DATA_WIDTH-1:0]     extImmD,
    output logic [REG_ADDR_WIDTH-1:0] rs1D,
    output logic [REG_ADDR_WIDTH-1:0] rs2D,
    output logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic [DATA_WIDTH-1:0]     pcE,
    input  logic [DATA_WIDTH-1:0]     pcPlus4E,
    input  logic [DATA_WIDTH-1:0]     rd1E,
    input  logic [DATA_WIDTH-1:0]     rd2E,
    input  logic [DATA_WIDTH-1:0]     immExtE,
    input  logic [REG_ADDR_WIDTH-1:0] rdE,
    input  logic [3:0]                aluControlE,
    input  logic [2:0]                addressingModeE,
    input  logic [1:0]                resultSrcE,
    input  logic                      aluSrcE,
    input  logic                      branchE,
    input  logic                      regWriteE,
    input  logic                      memWriteE,
    input  logic [1:0]                forwardAE,
    input  logic [1:0]                forwardBE,
    input  logic                      stallM,
    input  logic                      flushM,
    output logic [DATA_WIDTH-1:0]     aluResultE,
    output logic [DATA_WIDTH-1:0]     writeDataE,
    output logic [DATA_WIDTH-1:0]     branchTargetE,
    output logic                      branchTakenE,
    output logic [DATA_WIDTH-1:0]     pcPlus4M,
    output logic [DATA_WIDTH-1:0]     aluResultM,
    output logic [DATA_WIDTH-1:0]     writeDataM,
    output logic [REG_ADDR_WIDTH-1:0] rdM,
    output logic                      regWriteM,
    output logic                      memWriteM,
    output logic [1:0]                resultSrcM,
    output logic [2:0]                addressingModeM
);

    localparam int REG_COUNT = 2 ** REG_ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0]     ZERO      = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     ONE       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = {REG_ADDR_WIDTH{1'b0}};

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    function automatic logic [3:0] alu_op_f(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] branch_op_f(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b001: return ALU_SUB;
            3'b100, 3'b101: return ALU_SLT;
            3'b110, 3'b111: return ALU_SLTU;
            default:        return ALU_ADD;
        endcase
    endfunction

    // A pending writeback to the same index bypasses the array so ID sees this cycle's W result.
    function automatic logic [DATA_WIDTH-1:0] read_port_f(
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0]     stored,
        input logic                      wen,
        input logic [REG_ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0]     wdata
    );
        if (addr == ZERO_ADDR) return ZERO;
        else if (wen && (waddr != ZERO_ADDR) && (waddr == addr)) return wdata;
        else return stored;
    endfunction

    logic [DATA_WIDTH-1:0] reg_file_r [0:REG_COUNT-1];
    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic                  funct7b5_s;
    logic [DATA_WIDTH-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
    logic [DATA_WIDTH-1:0] src_a_s, src_b_s, alu_b_s, alu_result_s;
    logic [4:0]            shamt_s;
    logic                  branch_cond_s;

    logic [DATA_WIDTH-1:0]     pc_plus4_m_r, alu_result_m_r, write_data_m_r;
    logic [REG_ADDR_WIDTH-1:0] rd_m_r;
    logic                      reg_write_m_r, mem_write_m_r;
    logic [1:0]                result_src_m_r;
    logic [2:0]                addressing_mode_m_r;

    assign opcode_s   = instrD[6:0];
    assign funct3_s   = instrD[14:12];
    assign funct7b5_s = instrD[30];
    assign rs1D       = instrD[19:15];
    assign rs2D       = instrD[24:20];
    assign rdD        = instrD[11:7];

    assign imm_i_s = {{(DATA_WIDTH-12){instrD[31]}}, instrD[31:20]};
    assign imm_s_s = {{(DATA_WIDTH-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign imm_b_s = {{(DATA_WIDTH-12){instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
    assign imm_j_s = {{(DATA_WIDTH-20){instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
    assign imm_u_s = {instrD[31:12], {(DATA_WIDTH-20){1'b0}}};

    // Register file write port; x0 is never stored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) reg_file_r[i] <= ZERO;
        end else if (regWriteW && (rdW != ZERO_ADDR)) begin
            reg_file_r[rdW] <= resultW;
        end
    end

    assign rd1D        = read_port_f(rs1D, reg_file_r[rs1D], regWriteW, rdW, resultW);
    assign rd2D        = read_port_f(rs2D, reg_file_r[rs2D], regWriteW, rdW, resultW);
    assign testRegData = read_port_f(testRegAddr, reg_file_r[testRegAddr], regWriteW, rdW, resultW);

    // Opcode decode: controls, ALU op and immediate selection
    always_comb begin
        regWriteD       = 1'b0;
        memWriteD       = 1'b0;
        memReadD        = 1'b0;
        branchD         = 1'b0;
        jumpD           = 1'b0;
        jalrD           = 1'b0;
        aluSrcD         = 1'b0;
        resultSrcD      = 2'b00;
        aluControlD     = ALU_ADD;
        addressingModeD = funct3_s;
        extImmD         = ZERO;
        case (opcode_s)
            OP_R: begin
                regWriteD   = 1'b1;
                aluControlD = alu_op_f(funct3_s, funct7b5_s);
            end
            OP_I: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = alu_op_f(funct3_s, funct7b5_s & (funct3_s == 3'b101));
                extImmD     = imm_i_s;
            end
            OP_LOAD: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                memReadD   = 1'b1;
                resultSrcD = 2'b01;
                extImmD    = imm_i_s;
            end
            OP_STORE: begin
                memWriteD = 1'b1;
                aluSrcD   = 1'b1;
                extImmD   = imm_s_s;
            end
            OP_BRANCH: begin
                branchD     = 1'b1;
                aluControlD = branch_op_f(funct3_s);
                extImmD     = imm_b_s;
            end
            OP_JAL: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                resultSrcD = 2'b10;
                extImmD    = imm_j_s;
            end
            OP_JALR: begin
                regWriteD  = 1'b1;
                jumpD      = 1'b1;
                jalrD      = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b10;
                extImmD    = imm_i_s;
            end
            OP_LUI: begin
                regWriteD   = 1'b1;
                aluSrcD     = 1'b1;
                aluControlD = ALU_PASSB;
                extImmD     = imm_u_s;
            end
            default: begin
                addressingModeD = 3'b000;
            end
        endcase
    end

    // Operand forwarding and ALU B-source selection
    always_comb begin
        case (forwardAE)
            2'b01:   src_a_s = resultW;
            2'b10:   src_a_s = alu_result_m_r;
            default: src_a_s = rd1E;
        endcase
        case (forwardBE)
            2'b01:   src_b_s = resultW;
            2'b10:   src_b_s = alu_result_m_r;
            default: src_b_s = rd2E;
        endcase
        if (aluSrcE) alu_b_s = immExtE;
        else alu_b_s = src_b_s;
    end

    assign shamt_s = alu_b_s[4:0];

    // ALU
    always_comb begin
        case (aluControlE)
            ALU_ADD:   alu_result_s = src_a_s + alu_b_s;
            ALU_SUB:   alu_result_s = src_a_s - alu_b_s;
            ALU_AND:   alu_result_s = src_a_s & alu_b_s;
            ALU_OR:    alu_result_s = src_a_s | alu_b_s;
            ALU_XOR:   alu_result_s = src_a_s ^ alu_b_s;
            ALU_SLL:   alu_result_s = src_a_s << shamt_s;
            ALU_SRL:   alu_result_s = src_a_s >> shamt_s;
            ALU_SRA:   alu_result_s = $unsigned($signed(src_a_s) >>> shamt_s);
            ALU_SLT:   alu_result_s = ($signed(src_a_s) < $signed(alu_b_s)) ? ONE : ZERO;
            ALU_SLTU:  alu_result_s = (src_a_s < alu_b_s) ? ONE : ZERO;
            ALU_PASSB: alu_result_s = alu_b_s;
            default:   alu_result_s = ZERO;
        endcase
    end

    // Branch condition from the ALU result, keyed by funct3
    always_comb begin
        case (addressingModeE)
            3'b000:         branch_cond_s = (alu_result_s == ZERO);
            3'b001:         branch_cond_s = (alu_result_s != ZERO);
            3'b100, 3'b110: branch_cond_s = (alu_result_s == ONE);
            3'b101, 3'b111: branch_cond_s = (alu_result_s == ZERO);
            default:        branch_cond_s = 1'b0;
        endcase
    end

    assign aluResultE    = alu_result_s;
    assign writeDataE    = src_b_s;
    assign branchTargetE = pcE + immExtE;
    assign branchTakenE  = branchE & branch_cond_s;

    // EX/MEM register: a flush kills only the side-effecting controls
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_plus4_m_r        <= ZERO;
            alu_result_m_r      <= ZERO;
            write_data_m_r      <= ZERO;
            rd_m_r              <= ZERO_ADDR;
            reg_write_m_r       <= 1'b0;
            mem_write_m_r       <= 1'b0;
            result_src_m_r      <= 2'b00;
            addressing_mode_m_r <= 3'b000;
        end else if (flushM) begin
            pc_plus4_m_r        <= pcPlus4E;
            alu_result_m_r      <= alu_result_s;
            write_data_m_r      <= src_b_s;
            rd_m_r              <= rdE;
            reg_write_m_r       <= 1'b0;
            mem_write_m_r       <= 1'b0;
            result_src_m_r      <= 2'b00;
            addressing_mode_m_r <= addressingModeE;
        end else if (!stallM) begin
            pc_plus4_m_r        <= pcPlus4E;
            alu_result_m_r      <= alu_result_s;
            write_data_m_r      <= src_b_s;
            rd_m_r              <= rdE;
            reg_write_m_r       <= regWriteE;
            mem_write_m_r       <= memWriteE;
            result_src_m_r      <= resultSrcE;
            addressing_mode_m_r <= addressingModeE;
        end
    end

    assign pcPlus4M        = pc_plus4_m_r;
    assign aluResultM      = alu_result_m_r;
    assign writeDataM      = write_data_m_r;
    assign rdM             = rd_m_r;
    assign regWriteM       = reg_write_m_r;
    assign memWriteM       = mem_write_m_r;
    assign resultSrcM      = result_src_m_r;
    assign addressingModeM = addressing_mode_m_r;

endmodule

// File: tb/tb_decode_execute_mem_slice.sv
// Bench for decode_execute_mem_slice: directed scenarios, then random stimulus against a behavioural model.
module tb_decode_execute_mem_slice;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, regWriteW, stallM, flushM;
    logic [31:0] instrD, resultW, testRegData;
    logic [4:0]  rdW, testRegAddr, rs1D, rs2D, rdD, rdE, rdM;
    logic [2:0]  addressingModeD, addressingModeE, addressingModeM;
    logic [1:0]  resultSrcD, resultSrcE, resultSrcM, forwardAE, forwardBE;
    logic [3:0]  aluControlD, aluControlE;
    logic        regWriteD, memWriteD, memReadD, branchD, jumpD, jalrD, aluSrcD;
    logic [31:0] rd1D, rd2D, extImmD, pcE, pcPlus4E, rd1E, rd2E, immExtE;
    logic        aluSrcE, branchE, regWriteE, memWriteE, branchTakenE, regWriteM, memWriteM;
    logic [31:0] aluResultE, writeDataE, branchTargetE, pcPlus4M, aluResultM, writeDataM;

    decode_execute_mem_slice dut (
        .clk(clk), .rst(rst), .instrD(instrD), .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
        .testRegAddr(testRegAddr), .testRegData(testRegData), .addressingModeD(addressingModeD),
        .resultSrcD(resultSrcD), .aluControlD(aluControlD), .regWriteD(regWriteD), .memWriteD(memWriteD),
        .memReadD(memReadD), .branchD(branchD), .jumpD(jumpD), .jalrD(jalrD), .aluSrcD(aluSrcD),
        .rd1D(rd1D), .rd2D(rd2D), .extImmD(extImmD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .pcE(pcE), .pcPlus4E(pcPlus4E), .rd1E(rd1E), .rd2E(rd2E), .immExtE(immExtE), .rdE(rdE),
        .aluControlE(aluControlE), .addressingModeE(addressingModeE), .resultSrcE(resultSrcE),
        .aluSrcE(aluSrcE), .branchE(branchE), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallM(stallM), .flushM(flushM),
        .aluResultE(aluResultE), .writeDataE(writeDataE), .branchTargetE(branchTargetE),
        .branchTakenE(branchTakenE), .pcPlus4M(pcPlus4M), .aluResultM(aluResultM), .writeDataM(writeDataM),
        .rdM(rdM), .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
        .addressingModeM(addressingModeM)
    );

    int assert_count = 0;
    int fail_count   = 0;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic rw, mw, mr, br, jp, jr, as;
        logic [1:0] rs;
        logic [3:0] op;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc4, alu, wd;
        logic [4:0] rd;
        logic rw, mw;
        logic [1:0] rs;
        logic [2:0] am;
    } exm_t;

    logic [31:0] ref_regs [32];
    exm_t        ref_m;
    logic        ref_dc = 1'b0;  // EX/MEM data fields unknown after a flush

    function automatic logic [3:0] rv_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic dec_t decode_ref(input logic [31:0] ins);
        dec_t d;
        logic [2:0] f3;
        logic signed [11:0] i12, s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        d   = '0;
        f3  = ins[14:12];
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (ins[6:0])
            7'h33: begin d.rw = 1'b1; d.op = rv_alu(f3, ins[30]); end
            7'h13: begin d.rw = 1'b1; d.as = 1'b1; d.op = rv_alu(f3, (f3 == 3'd5) && ins[30]); d.imm = 32'(i12); end
            7'h03: begin d.rw = 1'b1; d.as = 1'b1; d.mr = 1'b1; d.rs = 2'd1; d.imm = 32'(i12); end
            7'h23: begin d.mw = 1'b1; d.as = 1'b1; d.imm = 32'(s12); end
            7'h63: begin d.br = 1'b1; d.op = !f3[2] ? 4'd1 : (f3[1] ? 4'd9 : 4'd8); d.imm = 32'(b13); end
            7'h6F: begin d.rw = 1'b1; d.jp = 1'b1; d.rs = 2'd2; d.imm = 32'(j21); end
            7'h67: begin d.rw = 1'b1; d.jp = 1'b1; d.jr = 1'b1; d.as = 1'b1; d.rs = 2'd2; d.imm = 32'(i12); end
            7'h37: begin d.rw = 1'b1; d.as = 1'b1; d.op = 4'd10; d.imm = {ins[31:12], 12'h000}; end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh, sa, sb;
        sh = int'(b[4:0]);
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rf_ref(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (regWriteW && rdW != 5'd0 && rdW == addr) return resultW;
        return ref_regs[addr];
    endfunction

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] regval);
        if (sel == 2'd1) return resultW;
        if (sel == 2'd2) return ref_m.alu;
        return regval;
    endfunction

    task automatic exec_ref(output logic [31:0] alu, output logic [31:0] wd,
                            output logic [31:0] tgt, output logic taken);
        logic [31:0] a, b;
        logic cond;
        a   = fwd_ref(forwardAE, rd1E);
        b   = fwd_ref(forwardBE, rd2E);
        wd  = b;
        alu = alu_ref(aluControlE, a, aluSrcE ? immExtE : b);
        tgt = pcE + immExtE;
        case (addressingModeE)
            3'd0, 3'd5, 3'd7: cond = (alu == 32'd0);
            3'd1:             cond = (alu != 32'd0);
            3'd4, 3'd6:       cond = (alu == 32'd1);
            default:          cond = 1'b0;
        endcase
        taken = branchE & cond;
    endtask

    // advance one clock and update the model with the inputs that were applied
    task automatic step();
        logic [31:0] ealu, ewd, etgt;
        logic etk;
        exec_ref(ealu, ewd, etgt, etk);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
            ref_m  = '0;
            ref_dc = 1'b0;
        end else begin
            if (regWriteW && rdW != 5'd0) ref_regs[rdW] = resultW;
            if (flushM) begin
                ref_m.rw = 1'b0; ref_m.mw = 1'b0; ref_m.rs = 2'd0;
                ref_dc   = 1'b1;
            end else if (!stallM) begin
                ref_m  = '{pc4: pcPlus4E, alu: ealu, wd: ewd, rd: rdE, rw: regWriteE,
                           mw: memWriteE, rs: resultSrcE, am: addressingModeE};
                ref_dc = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_all();
        dec_t d;
        logic [31:0] ealu, ewd, etgt;
        logic etk;
        d = decode_ref(instrD);
        check_value("regWriteD", 32'(regWriteD), 32'(d.rw));
        check_value("memWriteD", 32'(memWriteD), 32'(d.mw));
        check_value("memReadD", 32'(memReadD), 32'(d.mr));
        check_value("branchD", 32'(branchD), 32'(d.br));
        check_value("jumpD", 32'(jumpD), 32'(d.jp));
        check_value("jalrD", 32'(jalrD), 32'(d.jr));
        check_value("aluSrcD", 32'(aluSrcD), 32'(d.as));
        check_value("resultSrcD", 32'(resultSrcD), 32'(d.rs));
        check_value("aluControlD", 32'(aluControlD), 32'(d.op));
        check_value("extImmD", extImmD, d.imm);
        check_value("rs1D", 32'(rs1D), 32'(instrD[19:15]));
        check_value("rs2D", 32'(rs2D), 32'(instrD[24:20]));
        check_value("rdD", 32'(rdD), 32'(instrD[11:7]));
        if (instrD[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63})
            check_value("addressingModeD", 32'(addressingModeD), 32'(instrD[14:12]));
        check_value("rd1D", rd1D, rf_ref(instrD[19:15]));
        check_value("rd2D", rd2D, rf_ref(instrD[24:20]));
        check_value("testRegData", testRegData, rf_ref(testRegAddr));
        exec_ref(ealu, ewd, etgt, etk);
        check_value("aluResultE", aluResultE, ealu);
        check_value("writeDataE", writeDataE, ewd);
        check_value("branchTargetE", branchTargetE, etgt);
        check_value("branchTakenE", 32'(branchTakenE), 32'(etk));
        check_value("regWriteM", 32'(regWriteM), 32'(ref_m.rw));
        check_value("memWriteM", 32'(memWriteM), 32'(ref_m.mw));
        check_value("resultSrcM", 32'(resultSrcM), 32'(ref_m.rs));
        if (!ref_dc) begin
            check_value("pcPlus4M", pcPlus4M, ref_m.pc4);
            check_value("aluResultM", aluResultM, ref_m.alu);
            check_value("writeDataM", writeDataM, ref_m.wd);
            check_value("rdM", 32'(rdM), 32'(ref_m.rd));
            check_value("addressingModeM", 32'(addressingModeM), 32'(ref_m.am));
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4: ins[6:0] = 7'h63;
            5: ins[6:0] = 7'h6F;
            6: ins[6:0] = 7'h67;
            7: ins[6:0] = 7'h37;
            8: ins[6:0] = 7'h17;
            default: ins[6:0] = 7'($urandom);
        endcase
        if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
        return ins;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; regWriteW = 1'b0; rdW = 5'd0; resultW = 32'd0; testRegAddr = 5'd0; instrD = 32'd0;
        pcE = 32'd0; pcPlus4E = 32'd0; rd1E = 32'd0; rd2E = 32'd0; immExtE = 32'd0; rdE = 5'd0;
        aluControlE = 4'd0; addressingModeE = 3'd0; resultSrcE = 2'd0; aluSrcE = 1'b0; branchE = 1'b0;
        regWriteE = 1'b0; memWriteE = 1'b0; forwardAE = 2'd0; forwardBE = 2'd0; stallM = 1'b0; flushM = 1'b0;
        step();
        step();
        testRegAddr = 5'd7;
        #1;
        check_value("rst_aluResultM", aluResultM, 32'd0);
        check_value("rst_regWriteM", 32'(regWriteM), 32'd0);
        check_value("rst_pcPlus4M", pcPlus4M, 32'd0);
        check_value("rst_rdM", 32'(rdM), 32'd0);
        check_value("rst_x7", testRegData, 32'd0);

        // register file write / write-through / x0
        rst = 1'b0; regWriteW = 1'b1; rdW = 5'd5; resultW = 32'hDEADBEEF; testRegAddr = 5'd5;
        #1 check_value("wr_through_x5", testRegData, 32'hDEADBEEF);
        step();
        regWriteW = 1'b0;
        #1 check_value("rf_x5", testRegData, 32'hDEADBEEF);
        regWriteW = 1'b1; rdW = 5'd0; resultW = 32'h12345678; testRegAddr = 5'd0;
        #1 check_value("x0_write_through", testRegData, 32'd0);
        step();
        regWriteW = 1'b0;
        #1 check_value("x0_after_write", testRegData, 32'd0);

        // addi x1,x2,-3
        instrD = 32'hFFD10093;
        #1;
        check_value("addi_imm", extImmD, 32'hFFFFFFFD);
        check_value("addi_regWrite", 32'(regWriteD), 32'd1);
        check_value("addi_aluSrc", 32'(aluSrcD), 32'd1);
        check_value("addi_aluCtl", 32'(aluControlD), 32'd0);
        check_value("addi_rs1", 32'(rs1D), 32'd2);
        check_value("addi_rd", 32'(rdD), 32'd1);

        // ALU corner cases
        rd1E = 32'h80000000; immExtE = 32'd4; aluControlE = 4'd7; aluSrcE = 1'b1;
        #1 check_value("alu_sra", aluResultE, 32'hF8000000);
        rd1E = 32'd1; rd2E = 32'hFFFFFFFF; aluSrcE = 1'b0; aluControlE = 4'd9;
        #1 check_value("alu_sltu", aluResultE, 32'd1);

        // forwarding from EX/MEM and from W
        rd1E = 32'd7; immExtE = 32'd0; aluSrcE = 1'b1; aluControlE = 4'd0;
        step();
        check_value("fwd_setup_aluResultM", aluResultM, 32'd7);
        forwardAE = 2'd2; rd1E = 32'd0; rd2E = 32'd3; aluSrcE = 1'b0; aluControlE = 4'd1;
        #1 check_value("fwd_a_mem_sub", aluResultE, 32'd4);
        forwardBE = 2'd1; resultW = 32'd9;
        #1 check_value("fwd_b_wb", writeDataE, 32'd9);

        // branches
        forwardAE = 2'd0; forwardBE = 2'd0; rd1E = 32'hFFFFFFFF; rd2E = 32'd1; aluControlE = 4'd8;
        addressingModeE = 3'd4; branchE = 1'b1; pcE = 32'h100; immExtE = 32'hFFFFFFF0;
        #1;
        check_value("blt_taken", 32'(branchTakenE), 32'd1);
        check_value("blt_target", branchTargetE, 32'h000000F0);
        addressingModeE = 3'd5;
        #1 check_value("bge_not_taken", 32'(branchTakenE), 32'd0);

        // EX/MEM load, stall, flush, reset during stall
        branchE = 1'b0; pcPlus4E = 32'h104; regWriteE = 1'b1; memWriteE = 1'b1; resultSrcE = 2'd2;
        rdE = 5'd9; addressingModeE = 3'd3; rd1E = 32'h55; aluSrcE = 1'b1; immExtE = 32'h10;
        aluControlE = 4'd0; rd2E = 32'hA5;
        step();
        check_value("exm_regWriteM", 32'(regWriteM), 32'd1);
        check_value("exm_memWriteM", 32'(memWriteM), 32'd1);
        check_value("exm_resultSrcM", 32'(resultSrcM), 32'd2);
        check_value("exm_rdM", 32'(rdM), 32'd9);
        check_value("exm_pcPlus4M", pcPlus4M, 32'h104);
        check_value("exm_aluResultM", aluResultM, 32'h65);
        check_value("exm_writeDataM", writeDataM, 32'hA5);
        stallM = 1'b1; regWriteE = 1'b0; memWriteE = 1'b0; resultSrcE = 2'd1; rdE = 5'd3;
        pcPlus4E = 32'h200; rd1E = 32'h1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_value("stall_regWriteM", 32'(regWriteM), 32'd1);
            check_value("stall_rdM", 32'(rdM), 32'd9);
            check_value("stall_aluResultM", aluResultM, 32'h65);
        end
        stallM = 1'b0; flushM = 1'b1; regWriteE = 1'b1; memWriteE = 1'b1; resultSrcE = 2'd3;
        step();
        check_value("flush_regWriteM", 32'(regWriteM), 32'd0);
        check_value("flush_memWriteM", 32'(memWriteM), 32'd0);
        check_value("flush_resultSrcM", 32'(resultSrcM), 32'd0);
        flushM = 1'b0;
        step();
        check_value("reload_regWriteM", 32'(regWriteM), 32'd1);
        stallM = 1'b1; rst = 1'b1;
        step();
        testRegAddr = 5'd5;
        #1;
        check_value("rst_stall_regWriteM", 32'(regWriteM), 32'd0);
        check_value("rst_stall_memWriteM", 32'(memWriteM), 32'd0);
        check_value("rst_stall_resultSrcM", 32'(resultSrcM), 32'd0);
        check_value("rst_stall_rdM", 32'(rdM), 32'd0);
        check_value("rst_stall_pcPlus4M", pcPlus4M, 32'd0);
        check_value("rst_stall_aluResultM", aluResultM, 32'd0);
        check_value("rst_stall_writeDataM", writeDataM, 32'd0);
        check_value("rst_stall_addrModeM", 32'(addressingModeM), 32'd0);
        check_value("rst_clears_x5", testRegData, 32'd0);
        rst = 1'b0; stallM = 1'b0;

        // randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            rst         = ($urandom_range(0, 39) == 0);
            instrD      = gen_instr();
            regWriteW   = 1'($urandom);
            rdW         = 5'($urandom);
            resultW     = $urandom;
            testRegAddr = 5'($urandom);
            pcE         = $urandom;
            pcPlus4E    = $urandom;
            rd1E        = $urandom;
            rd2E        = ($urandom_range(0, 3) == 0) ? rd1E : $urandom;
            immExtE     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rdE         = 5'($urandom);
            aluControlE = 4'($urandom_range(0, 10));
            addressingModeE = 3'($urandom);
            resultSrcE  = 2'($urandom);
            aluSrcE     = 1'($urandom);
            branchE     = 1'($urandom);
            regWriteE   = 1'($urandom);
            memWriteE   = 1'($urandom);
            forwardAE   = 2'($urandom);
            forwardBE   = 2'($urandom);
            if (ref_dc && forwardAE == 2'd2) forwardAE = 2'd0;
            if (ref_dc && forwardBE == 2'd2) forwardBE = 2'd3;
            stallM      = ($urandom_range(0, 4) == 0);
            flushM      = ($urandom_range(0, 5) == 0);
            #1;
            check_all();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/decode_execute_mem_slice.md
Name: decode_execute_mem_slice

Overview:
- Datapath slice of the 5-stage RV32I pipeline, with three parts:
  - Decode: instruction decoder, immediate generator and 32x32 register file.
  - Execute: forwarding muxes, ALU, branch resolution.
  - EX/MEM: pipeline register.
- Decode outputs go to the external ID/EX register.
- Execute takes E-stage operands from that register.
- The EX/MEM register output aluResultM is fed back internally for forwarding.

Parameters:
- DATA_WIDTH, 32, datapath width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instrD  in  32  instruction in ID.
- regWriteW, rdW, resultW  in  1/5/32  writeback enable, destination, data.
- testRegAddr / testRegData  in/out  5/32  combinational debug read port.
- addressingModeD, resultSrcD, aluControlD  out  3/2/4  funct3, result select, ALU op.
- regWriteD, memWriteD, memReadD, branchD, jumpD, jalrD, aluSrcD  out  1 each  decoded controls.
- rd1D, rd2D, extImmD  out  32  register reads, sign-extended immediate.
- rs1D, rs2D, rdD  out  5  instr[19:15], instr[24:20], instr[11:7].
- pcE, pcPlus4E, rd1E, rd2E, immExtE  in  32  E-stage data.
- rdE, aluControlE, addressingModeE, resultSrcE  in  5/4/3/2  E-stage fields.
- aluSrcE, branchE, regWriteE, memWriteE  in  1 each  E-stage controls.
- forwardAE, forwardBE  in  2  forwarding selects.
- stallM, flushM  in  1  EX/MEM hold / bubble.
- aluResultE, writeDataE, branchTargetE  out  32  execute results.
- branchTakenE  out  1  conditional branch taken.
- pcPlus4M, aluResultM, writeDataM  out  32  EX/MEM data.
- rdM, regWriteM, memWriteM, resultSrcM, addressingModeM  out  5/1/1/2/3  EX/MEM fields.

Behaviour:
- Register file:
  - x0 always reads 0.
  - Write on rising clk when regWriteW=1 and rdW≠0.
  - Reads are combinational with write-through: if regWriteW, rdW≠0 and rdW equals the read index, return resultW.
  - rst clears all registers to 0. The test port uses the same read path.
- Decode, by opcode (everything not listed is 0):
  - R 0110011: regWrite=1.
  - I-ALU 0010011: regWrite, aluSrc.
  - Load 0000011: regWrite, aluSrc, memRead, resultSrc=01, ADD.
  - Store 0100011: memWrite, aluSrc, ADD.
  - Branch 1100011: branch.
  - JAL 1101111: regWrite, jump, resultSrc=10.
  - JALR 1100111: regWrite, jump, jalr, aluSrc, resultSrc=10, ADD.
  - LUI 0110111: regWrite, aluSrc, PASSB.
  - Any other opcode, including AUIPC: all controls 0 (NOP).
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB.
  - R/I-ALU ops follow funct3 and funct7[5]. SUB is R-type only; SRA/SRAI use funct7[5].
  - Branch ALU op: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
- Immediates:
  - I: {20{i31}, i[31:20]}.
  - S: i[31:25], i[11:7].
  - B: i31, i7, i[30:25], i[11:8], 0.
  - J: i31, i[19:12], i20, i[30:21], 0.
  - U: i[31:12], 12'b0.
  - Non-immediate opcodes: 0.
- Forwarding:
  - A mux: 00 rd1E, 01 resultW, 10 aluResultM (internal EX/MEM Q), 11 rd1E. B mux identical.
  - writeDataE = forwarded B.
  - ALU B input = aluSrcE ? immExtE : forwarded B.
- ALU:
  - Shift amount is B[4:0].
  - SLT signed, SLTU unsigned; result 0/1.
  - 32-bit wrap-around, no flags.
- Branch:
  - branchTargetE = pcE + immExtE (mod 2^32).
  - branchTakenE = branchE & condition, by funct3:
    - 000: ALU==0
    - 001: ALU≠0
    - 100/110: ALU==1
    - 101/111: ALU==0
    - other: 0
  - Execute logic is purely combinational.
- EX/MEM, priority rst > flushM > stallM > load:
  - rst: all outputs 0.
  - flushM: regWriteM, memWriteM, resultSrcM go to 0; data fields may load.
  - stallM: every field holds.
  - Otherwise every field captures its E input, latency 1 cycle.

Test Plan:
- Write/read: regWriteW=1, rdW=5, resultW=0xDEADBEEF, clock → testRegAddr=5 reads 0xDEADBEEF. The same with rdW=0 leaves x0 reading 0.
- Decode `addi x1,x2,-3` (0xFFD10093) → extImmD=0xFFFFFFFD, regWriteD=1, aluSrcD=1, aluControlD=0000, rs1D=2, rdD=1.
- ALU: rd1E=0x80000000, imm=4, SRA, aluSrcE=1 → aluResultE=0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1.
- Forwarding: aluResultM=7, forwardAE=10, rd2E=3, SUB → aluResultE=4. forwardBE=01, resultW=9 → writeDataE=9.
- Branch: BLT, pcE=0x100, imm=0xFFFFFFF0, rd1E=-1, rd2E=1, branchE=1 → branchTakenE=1, branchTargetE=0xF0. BGE with the same operands → 0.
- EX/MEM: load values, assert stallM 3 cycles → outputs hold. flushM → regWriteM=memWriteM=0, resultSrcM=0. rst mid-stall → all 0.
